// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
// Imported by the controller and its parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_parity_gen.sv
// Parity bit for one UART data word.
// Even parity is the XOR of the word; odd parity is its inverse.
module uart_parity_gen #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             odd,
    output logic             parity
);

    assign parity = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, LSB-first data, optional parity,
// one or two stop bits, with a valid/ready front end.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_en,
    input  logic                 parity_even_n,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_tx_state_t state;

    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     idx_next;
    logic [DATA_BITS-1:0] sh_data;
    logic                 sh_par_en;
    logic                 sh_odd;
    logic                 sh_two;
    logic                 stop_second;
    logic                 par_bit;
    logic                 wrap;

    assign wrap     = (cnt == CNT_LAST);
    assign idx_next = bit_idx + IDX_W'(1);
    assign tx_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    uart_parity_gen #(
        .WIDTH (DATA_BITS)
    ) u_parity (
        .data   (sh_data),
        .odd    (sh_odd),
        .parity (par_bit)
    );

    // tx is loaded on the edge that enters each bit, so it only moves
    // at bit boundaries and every bit spans a full counter period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx          <= STOP_BIT;
            tx_done     <= 1'b0;
            cnt         <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            sh_data     <= '0;
            sh_par_en   <= 1'b0;
            sh_odd      <= 1'b0;
            sh_two      <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            if (state != ST_IDLE) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end

            unique case (state)
                ST_IDLE: begin
                    tx <= STOP_BIT;
                    if (tx_valid) begin
                        sh_data     <= tx_data;
                        sh_par_en   <= parity_en;
                        sh_odd      <= parity_even_n;
                        sh_two      <= two_stop;
                        cnt         <= '0;
                        bit_idx     <= '0;
                        stop_second <= 1'b0;
                        tx          <= START_BIT;
                        state       <= ST_START;
                    end
                end

                ST_START: begin
                    if (wrap) begin
                        tx    <= sh_data[0];
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (wrap) begin
                        if (bit_idx == IDX_LAST) begin
                            if (sh_par_en) begin
                                tx    <= par_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= STOP_BIT;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_idx <= idx_next;
                            tx      <= sh_data[idx_next];
                        end
                    end
                end

                ST_PARITY: begin
                    if (wrap) begin
                        tx    <= STOP_BIT;
                        state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (wrap) begin
                        if (sh_two && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            tx_done <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    tx    <= STOP_BIT;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4, DATA_BITS=8.
// Frame vectors hold the expected line level per bit period in send order.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          parity_en;
    logic          parity_even_n;
    logic          two_stop;
    logic          tx;
    logic          busy;
    logic          tx_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .DATA_BITS    (DB),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .parity_en     (parity_en),
        .parity_even_n (parity_even_n),
        .two_stop      (two_stop),
        .tx            (tx),
        .busy          (busy),
        .tx_done       (tx_done)
    );

    typedef struct {
        logic [7:0]  data;
        logic        pen;
        logic        odd;
        logic        two;
        logic [0:11] bits;
        int          len;
        logic        scramble;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Entered at the falling edge right after the accepting edge.
    // Leaves at the falling edge of the tx_done cycle.
    task automatic check_frame(input logic [0:11] bits, input int len,
                               input logic scramble);
        for (int p = 0; p < len; p++) begin
            for (int c = 0; c < CPB; c++) begin
                if (scramble && p == 3 && c == 0) begin
                    tx_data       = ~tx_data;
                    two_stop      = ~two_stop;
                    parity_even_n = ~parity_even_n;
                    parity_en     = ~parity_en;
                    tx_valid      = 1'b1;
                end
                if (scramble && p == 3 && c == 1) tx_valid = 1'b0;
                chk($sformatf("tx p%0d c%0d", p, c), tx, bits[p]);
                chk($sformatf("busy p%0d c%0d", p, c), busy, 1);
                chk($sformatf("ready p%0d c%0d", p, c), tx_ready, 0);
                chk($sformatf("done early p%0d c%0d", p, c), tx_done, 0);
                @(negedge clk);
            end
        end
        chk("done pulse", tx_done, 1);
        chk("ready at done", tx_ready, 1);
        chk("busy at done", busy, 0);
        chk("tx at done", tx, 1);
    endtask

    task automatic send(input vec_t v);
        @(negedge clk);
        tx_data       = v.data;
        parity_en     = v.pen;
        parity_even_n = v.odd;
        two_stop      = v.two;
        tx_valid      = 1'b1;
        chk("ready before send", tx_ready, 1);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        check_frame(v.bits, v.len, v.scramble);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("after done %0d", i), tx_done, 0);
            chk($sformatf("idle busy %0d", i), busy, 0);
            chk($sformatf("idle tx %0d", i), tx, 1);
        end
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'b010100101111, 10, 1'b0};
        vecs[1] = '{8'h55, 1'b1, 1'b0, 1'b0, 12'b010101010011, 11, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b0, 12'b010101010111, 11, 1'b0};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b0, 12'b011100000111, 11, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 12'b011111111011, 12, 1'b1};
        vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b1, 12'b000111100111, 11, 1'b0};

        rst           = 1'b1;
        tx_data       = '0;
        tx_valid      = 1'b0;
        parity_en     = 1'b0;
        parity_even_n = 1'b0;
        two_stop      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset tx", tx, 1);
        chk("reset ready", tx_ready, 1);
        chk("reset busy", busy, 0);
        chk("reset done", tx_done, 0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle tx %0d", i), tx, 1);
            chk($sformatf("idle ready %0d", i), tx_ready, 1);
            chk($sformatf("idle busy %0d", i), busy, 0);
        end

        for (int i = 0; i < 6; i++) send(vecs[i]);

        // Back-to-back with tx_valid held high across both frames.
        @(negedge clk);
        tx_data   = 8'h01;
        parity_en = 1'b0;
        two_stop  = 1'b0;
        tx_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data = 8'h80;
        check_frame(12'b010000000111, 10, 1'b0);
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b second start", tx, 0);
        check_frame(12'b000000001111, 10, 1'b0);

        // Reset during data bit 3 of 0xA5.
        @(negedge clk);
        tx_data   = 8'hA5;
        parity_en = 1'b0;
        two_stop  = 1'b0;
        tx_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("bit3 before rst", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst tx", tx, 1);
        chk("rst ready", tx_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst done", tx_done, 0);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            chk($sformatf("post rst done %0d", i), tx_done, 0);
            chk($sformatf("post rst tx %0d", i), tx, 1);
        end
        send(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
